// File: rtl/receiver_spi_pkg.sv
// Shared SPI definitions: default sizes, FSM encoding and CPH/CKP mode constants.
package receiver_spi_pkg;

  localparam int unsigned WIDTH_DEF       = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic CPH_LEADING   = 1'b0;
  localparam logic CPH_TRAILING  = 1'b1;
  localparam logic CKP_IDLE_LOW  = 1'b0;
  localparam logic CKP_IDLE_HIGH = 1'b1;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous input plus one-flop rise/fall detector.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Reset value is a port so the SCK instance can preset to its idle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= {STAGES{init}};
      prev  <= init;
    end else begin
      chain <= STAGES'({chain, din});
      prev  <= chain[STAGES-1];
    end
  end

  assign level  = chain[STAGES-1];
  assign rise_c = level & ~prev;
  assign fall_c = ~level & prev;

endmodule

// File: rtl/receiver_spi.sv
// SPI slave receiver: oversampled SCK/CS/MOSI, mode latched per frame, full-duplex reply on MISO.
module receiver_spi
  import receiver_spi_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CPH,
  input  logic             CKP,
  input  logic             CS,
  input  logic             SCK,
  input  logic             MOSI,
  input  logic [WIDTH-1:0] tx_data,
  output logic             MISO,
  output logic [WIDTH-1:0] data_out,
  output logic             rx_valid,
  output logic             tx_ack,
  output logic             busy,
  output logic             frame_err
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic sck_level_unused, sck_rise, sck_fall;
  logic cs_level_unused, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .rst(rst), .init(CKP), .din(SCK),
    .level(sck_level_unused), .rise_c(sck_rise), .fall_c(sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst(rst), .init(1'b0), .din(CS),
    .level(cs_level_unused), .rise_c(cs_rise), .fall_c(cs_fall)
  );

  // MOSI goes through the same chain so it stays aligned with the SCK edges.
  sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk), .rst(rst), .init(1'b0), .din(MOSI),
    .level(mosi_s), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
  );

  state_t             state, state_d;
  logic               cph_q, cph_d, ckp_q, ckp_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [WIDTH-1:0]   rx_sh, rx_sh_d, tx_sh, tx_sh_d, data_out_d;
  logic               miso_d, rx_valid_d, tx_ack_d, frame_err_d;
  logic               leading, trailing, sample_edge, shift_edge;
  logic [WIDTH-1:0]   rx_next;

  assign leading     = (ckp_q == CKP_IDLE_HIGH) ? sck_fall : sck_rise;
  assign trailing    = (ckp_q == CKP_IDLE_HIGH) ? sck_rise : sck_fall;
  assign sample_edge = (cph_q == CPH_TRAILING) ? trailing : leading;
  assign shift_edge  = (cph_q == CPH_TRAILING) ? leading : trailing;
  assign rx_next     = WIDTH'({rx_sh, mosi_s});
  assign busy        = (state == ACTIVE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cph_q     <= CPH_LEADING;
      ckp_q     <= CKP_IDLE_LOW;
      cnt       <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      MISO      <= 1'b0;
      data_out  <= '0;
      rx_valid  <= 1'b0;
      tx_ack    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      cph_q     <= cph_d;
      ckp_q     <= ckp_d;
      cnt       <= cnt_d;
      rx_sh     <= rx_sh_d;
      tx_sh     <= tx_sh_d;
      MISO      <= miso_d;
      data_out  <= data_out_d;
      rx_valid  <= rx_valid_d;
      tx_ack    <= tx_ack_d;
      frame_err <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state;
    cph_d       = cph_q;
    ckp_d       = ckp_q;
    cnt_d       = cnt;
    rx_sh_d     = rx_sh;
    tx_sh_d     = tx_sh;
    miso_d      = MISO;
    data_out_d  = data_out;
    rx_valid_d  = 1'b0;
    tx_ack_d    = 1'b0;
    frame_err_d = 1'b0;

    case (state)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d  = ACTIVE;
          cph_d    = CPH;
          ckp_d    = CKP;
          cnt_d    = '0;
          rx_sh_d  = '0;
          tx_ack_d = 1'b1;
          // Leading-edge sampling needs the first reply bit on MISO before the first SCK edge.
          if (CPH == CPH_LEADING) begin
            miso_d  = tx_data[WIDTH-1];
            tx_sh_d = WIDTH'({tx_data, 1'b0});
          end else begin
            tx_sh_d = tx_data;
          end
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d     = IDLE;
          miso_d      = 1'b0;
          frame_err_d = (cnt != '0);
        end else begin
          if (shift_edge) begin
            miso_d  = tx_sh[WIDTH-1];
            tx_sh_d = WIDTH'({tx_sh, 1'b0});
          end
          if (sample_edge) begin
            rx_sh_d = rx_next;
            cnt_d   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              data_out_d = rx_next;
              rx_valid_d = 1'b1;
              cnt_d      = '0;
              tx_sh_d    = tx_data;
              tx_ack_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
